wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the MDU result FIFO depth in entries (power of two, at least 2).
REQ-002 Parameter STARVE_LIMIT, default 4, SHALL set the number of consecutive cycles a queued MDU result may wait before it forces a grant.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 Ports pipe_valid, pipe_rd, pipe_data  input  1/5/`WORD  SHALL carry the WB-stage write request, destination register, and the selected ALU-or-memory result.
REQ-006 Port pipe_stall  output  1  SHALL, when high, tell the pipeline that its WB request was not accepted and must be held.
REQ-007 Ports mdu_valid, mdu_rd, mdu_data  input  1/5/`WORD  SHALL carry a multi-cycle multiply/divide result.
REQ-008 Port mdu_ready  output  1  SHALL accept an MDU result when mdu_valid and mdu_ready are both high.
REQ-009 Port mdu_busy  input  1  SHALL indicate that an MDU operation is in flight.
REQ-010 Port terminate  input  1  SHALL request a halt, as a one-cycle pulse or a level.
REQ-011 Ports rf_we, rf_waddr, rf_wdata  output  1/5/`WORD  SHALL drive the single register-file write port.
REQ-012 Port halted  output  1  SHALL indicate that the drain has completed.

Function
REQ-013 Write-port outputs SHALL be registered: a request granted in cycle N appears on rf_* in cycle N+1.
REQ-014 A granted request with rd==0 SHALL produce rf_we=0, with rf_waddr and rf_wdata still updated.
REQ-015 MDU results SHALL enter a DEPTH-entry FIFO with wrapping pointers. mdu_ready = !full, computed from the current count only. A push while full SHALL be impossible; push and pop in the same cycle SHALL leave count unchanged.
REQ-016 Default priority SHALL go to the pipeline: pipe_valid grants the pipe and pipe_stall=0. The FIFO head is granted only when pipe_valid=0 and the FIFO is non-empty.
REQ-017 A starve counter SHALL increment each cycle the FIFO is non-empty and its head is not granted. It SHALL clear on any FIFO pop or when the FIFO is empty, and saturate at STARVE_LIMIT.
REQ-018 When starve==STARVE_LIMIT and the FIFO is non-empty, the head SHALL be granted and pipe_stall=pipe_valid (combinational) for that cycle.
REQ-019 The FSM SHALL have states RUN, DRAIN and HALTED.
- RUN->DRAIN when terminate=1.
- DRAIN->HALTED when the FIFO is empty, mdu_busy=0 and mdu_valid=0.
- HALTED SHALL be terminal until reset.
REQ-020 In DRAIN, pipe requests SHALL still be granted; the pipeline itself stops fetching.
REQ-021 In HALTED: halted=1, pipe_stall=1, mdu_ready=0, and rf_we=0 from the cycle after entry.
REQ-022 terminate in DRAIN or HALTED SHALL be ignored.
REQ-023 Per-source ordering SHALL be preserved; MDU entries pop strictly in FIFO order.

Reset
REQ-024 Assertion of rst_n=0 SHALL immediately clear the following, regardless of clk, including mid-drain or with the FIFO full:
- rf_we=0, rf_waddr=0, rf_wdata=0;
- FIFO pointers and count=0, starve=0;
- state=RUN, halted=0.
REQ-025 FIFO data storage need not be reset.
REQ-026 Immediately after reset: mdu_ready=1 and pipe_stall=0.

Structure
REQ-027 `WORD, the register-index width (5) and the FSM state encodings SHALL live in constants.v.
REQ-028 The MDU FIFO SHALL be a sub-module named wb_fifo (parameter DEPTH, payload {rd, data}).
REQ-029 Arbitration, starve counter and FSM SHALL be in wb_arbiter.

Verification
REQ-030 Pipe-only traffic: pipe_valid=1, rd=3, data=0x0000_00AA in cycle 0 -> rf_we=1, rf_waddr=3, rf_wdata=0xAA in cycle 1; pipe_stall=0 throughout.
REQ-031 MDU with an idle pipe: push rd=5, data=0x1234 -> written on rf_* 2 cycles after the push (cycle +1 pop, +2 visible).
REQ-032 Starvation: push rd=7 while pipe_valid=1 continuously -> head granted in the 5th waiting cycle with pipe_stall=1 exactly that cycle; rf_waddr=7 one cycle later.
REQ-033 FIFO full: two MDU pushes with pipe_valid=1 -> mdu_ready=0. Then drop pipe_valid -> one pop, and mdu_ready=1 the next cycle.
REQ-034 Terminate with 2 queued entries and mdu_busy=1 for 3 cycles -> both entries written, then halted=1 only after mdu_busy=0 and the FIFO is empty. Writes with rd=0 show rf_we=0.
REQ-035 Assert rst_n=0 in mid-DRAIN, asynchronously between edges -> all outputs reach reset values without a clock edge; the FIFO reports empty after release.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the write-back arbiter: data word width,
// register index width, FSM state encodings and the MDU FIFO payload.
package wb_arbiter_pkg;

  localparam int WORD  = 32;
  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } arb_state_e;

  // One queued MDU result: destination register plus value.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [WORD-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO holding multiply/divide results until the register-file write
// port is free. The head is read combinationally so the arbiter can grant it
// in the same cycle it is seen; pointers wrap naturally because DEPTH is a
// power of two.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      empty,
  output logic      full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW:0]     count_reg;
  logic            do_push;
  logic            do_pop;

  // Count reaches DEPTH exactly when its top bit sets (DEPTH is a power of two).
  assign full    = count_reg[PW];
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  // Payload storage: no reset needed, validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_entry;
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: shares the single register-file write port between the
// in-order pipeline and queued multiply/divide results. The pipeline wins by
// default; a starve counter forces the MDU head through after STARVE_LIMIT
// waiting cycles. A terminate request drains outstanding MDU work, then halts.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pipe_valid,
  input  logic [REG_W-1:0] pipe_rd,
  input  logic [WORD-1:0]  pipe_data,
  output logic             pipe_stall,
  input  logic             mdu_valid,
  input  logic [REG_W-1:0] mdu_rd,
  input  logic [WORD-1:0]  mdu_data,
  output logic             mdu_ready,
  input  logic             mdu_busy,
  input  logic             terminate,
  output logic             rf_we,
  output logic [REG_W-1:0] rf_waddr,
  output logic [WORD-1:0]  rf_wdata,
  output logic             halted
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e       state_reg;
  logic [SW-1:0]    starve_reg;
  logic             rf_we_reg;
  logic [REG_W-1:0] rf_waddr_reg;
  logic [WORD-1:0]  rf_wdata_reg;

  wb_entry_t        head_entry;
  wb_entry_t        push_entry;
  wb_entry_t        wr_entry;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             grant_mdu;
  logic             grant_any;

  assign mdu_ready  = !fifo_full && (state_reg != ST_HALTED);
  assign push       = mdu_valid && mdu_ready;
  assign push_entry = '{rd: mdu_rd, data: mdu_data};
  assign halted     = (state_reg == ST_HALTED);
  assign rf_we      = rf_we_reg;
  assign rf_waddr   = rf_waddr_reg;
  assign rf_wdata   = rf_wdata_reg;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_entry(push_entry),
    .pop       (grant_mdu),
    .head      (head_entry),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Pick this cycle's writer: pipe first, MDU head when idle or starved.
  always_comb begin
    grant_mdu  = 1'b0;
    grant_any  = 1'b0;
    pipe_stall = 1'b0;
    wr_entry   = '{rd: pipe_rd, data: pipe_data};
    if (state_reg == ST_HALTED) begin
      pipe_stall = 1'b1;
    end else if (!fifo_empty && (starve_reg == STARVE_MAX || !pipe_valid)) begin
      grant_mdu  = 1'b1;
      grant_any  = 1'b1;
      pipe_stall = pipe_valid;
      wr_entry   = head_entry;
    end else if (pipe_valid) begin
      grant_any = 1'b1;
    end
  end

  // Registered write port; writes to r0 keep address/data but drop the enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
    end else begin
      rf_we_reg <= grant_any && (wr_entry.rd != '0);
      if (grant_any) begin
        rf_waddr_reg <= wr_entry.rd;
        rf_wdata_reg <= wr_entry.data;
      end
    end
  end

  // Count cycles the queued head waits, saturating at the forcing threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_reg <= '0;
    end else if (fifo_empty || grant_mdu) begin
      starve_reg <= '0;
    end else if (starve_reg != STARVE_MAX) begin
      starve_reg <= starve_reg + 1'b1;
    end
  end

  // Run / drain / halt sequencing; halt waits for all MDU work to retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
    end else begin
      case (state_reg)
        ST_RUN:    if (terminate) state_reg <= ST_DRAIN;
        ST_DRAIN:  if (fifo_empty && !mdu_busy && !mdu_valid) state_reg <= ST_HALTED;
        ST_HALTED: state_reg <= ST_HALTED;
        default:   state_reg <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios with fixed expectations, then
// randomized traffic compared against a queue-based reference model.
module tb_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_valid = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_data = '0;
  logic        pipe_stall;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_rd = '0;
  logic [31:0] mdu_data = '0;
  logic        mdu_ready;
  logic        mdu_busy = 1'b0;
  logic        terminate = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        halted;

  int checks = 0;
  int failures = 0;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .mdu_busy(mdu_busy), .terminate(terminate),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    mdu_busy = 0; terminate = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #3;
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_rf: we=%b waddr=%0d wdata=%h want 0/0/0", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (mdu_ready !== 1'b1 || pipe_stall !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl: ready=%b stall=%b halted=%b want 1/0/0", mdu_ready, pipe_stall, halted);
    end
    do_reset();
    $display("test_reset done");
  endtask

  task automatic test_pipe_only();
    do_reset();
    pipe_valid = 1; pipe_rd = 3; pipe_data = 32'h0000_00AA;
    #1;
    checks++;
    if (pipe_stall !== 1'b0) begin
      failures++; $display("FAIL pipe_stall: got %b want 0", pipe_stall);
    end
    cyc();
    pipe_valid = 0;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hAA) begin
      failures++;
      $display("FAIL pipe_write: we=%b waddr=%0d wdata=%h want 1/3/aa", rf_we, rf_waddr, rf_wdata);
    end
    $display("test_pipe_only: rd=3 data=aa written");
  endtask

  task automatic test_mdu_idle();
    do_reset();
    mdu_valid = 1; mdu_rd = 5; mdu_data = 32'h1234;
    #1;
    checks++;
    if (mdu_ready !== 1'b1) begin
      failures++; $display("FAIL mdu_ready_idle: got %b want 1", mdu_ready);
    end
    cyc();
    mdu_valid = 0;
    checks++;
    if (rf_we !== 1'b0) begin
      failures++; $display("FAIL mdu_early: rf_we=%b want 0 one cycle after push", rf_we);
    end
    cyc();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
      failures++;
      $display("FAIL mdu_write: we=%b waddr=%0d wdata=%h want 1/5/1234", rf_we, rf_waddr, rf_wdata);
    end
    $display("test_mdu_idle: rd=5 data=1234 written at push+2");
  endtask

  task automatic test_starve();
    do_reset();
    pipe_valid = 1; pipe_rd = 1; pipe_data = 32'h11;
    mdu_valid = 1; mdu_rd = 7; mdu_data = 32'h7777;
    cyc();
    mdu_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      pipe_data = (k == 6) ? 32'd5 : k;
      #1;
      checks++;
      if (pipe_stall !== (k == 5)) begin
        failures++; $display("FAIL starve_stall: wait cycle %0d stall=%b want %b", k, pipe_stall, (k == 5));
      end
      cyc();
      checks++;
      if (k == 5) begin
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h7777) begin
          failures++;
          $display("FAIL starve_grant: we=%b waddr=%0d wdata=%h want 1/7/7777", rf_we, rf_waddr, rf_wdata);
        end
      end else if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== ((k == 6) ? 32'd5 : k)) begin
        failures++;
        $display("FAIL starve_pipe: cycle %0d we=%b waddr=%0d wdata=%h want pipe rd=1", k, rf_we, rf_waddr, rf_wdata);
      end
    end
    pipe_valid = 0;
    $display("test_starve: head forced on 5th waiting cycle");
  endtask

  task automatic test_fifo_full();
    do_reset();
    pipe_valid = 1; pipe_rd = 2; pipe_data = 32'h22;
    mdu_valid = 1; mdu_rd = 10; mdu_data = 32'hA;
    cyc();
    mdu_rd = 11; mdu_data = 32'hB;
    cyc();
    mdu_valid = 0; pipe_valid = 0;
    #1;
    checks++;
    if (mdu_ready !== 1'b0) begin
      failures++; $display("FAIL full_ready: got %b want 0", mdu_ready);
    end
    cyc();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'hA || mdu_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_pop1: we=%b waddr=%0d wdata=%h ready=%b want 1/10/a/1", rf_we, rf_waddr, rf_wdata, mdu_ready);
    end
    cyc();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'hB) begin
      failures++;
      $display("FAIL full_pop2: we=%b waddr=%0d wdata=%h want 1/11/b", rf_we, rf_waddr, rf_wdata);
    end
    $display("test_fifo_full: ready dropped when full, entries popped in order");
  endtask

  task automatic test_drain();
    do_reset();
    mdu_busy = 1;
    pipe_valid = 1; pipe_rd = 2; pipe_data = 32'h2;
    mdu_valid = 1; mdu_rd = 0; mdu_data = 32'hD0D0;
    cyc();
    mdu_rd = 9; mdu_data = 32'hD1D1;
    cyc();
    mdu_valid = 0; pipe_valid = 0; terminate = 1;
    cyc();
    terminate = 0;
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'hD0D0) begin
      failures++;
      $display("FAIL drain_r0: we=%b waddr=%0d wdata=%h want 0/0/d0d0", rf_we, rf_waddr, rf_wdata);
    end
    cyc();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hD1D1 || halted !== 1'b0) begin
      failures++;
      $display("FAIL drain_r9: we=%b waddr=%0d wdata=%h halted=%b want 1/9/d1d1/0", rf_we, rf_waddr, rf_wdata, halted);
    end
    cyc();
    checks++;
    if (halted !== 1'b0) begin
      failures++; $display("FAIL drain_busy: halted=%b want 0 while mdu_busy", halted);
    end
    mdu_busy = 0;
    cyc();
    checks++;
    if (halted !== 1'b1 || rf_we !== 1'b0) begin
      failures++; $display("FAIL drain_halt: halted=%b we=%b want 1/0", halted, rf_we);
    end
    pipe_valid = 1; pipe_rd = 4; mdu_valid = 1; terminate = 1;
    #1;
    checks++;
    if (pipe_stall !== 1'b1 || mdu_ready !== 1'b0) begin
      failures++; $display("FAIL halt_ctl: stall=%b ready=%b want 1/0", pipe_stall, mdu_ready);
    end
    cyc();
    checks++;
    if (rf_we !== 1'b0 || halted !== 1'b1) begin
      failures++; $display("FAIL halt_hold: we=%b halted=%b want 0/1", rf_we, halted);
    end
    clear_inputs();
    $display("test_drain: both entries retired, halted after busy cleared");
  endtask

  task automatic test_async_reset();
    do_reset();
    mdu_busy = 1;
    pipe_valid = 1; pipe_rd = 4; pipe_data = 32'h44;
    mdu_valid = 1; mdu_rd = 6; mdu_data = 32'h66;
    cyc();
    cyc();
    mdu_valid = 0; terminate = 1;
    cyc();
    terminate = 0;
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL async_rf: we=%b waddr=%0d wdata=%h halted=%b want 0/0/0/0", rf_we, rf_waddr, rf_wdata, halted);
    end
    checks++;
    if (mdu_ready !== 1'b1 || pipe_stall !== 1'b0) begin
      failures++; $display("FAIL async_ctl: ready=%b stall=%b want 1/0", mdu_ready, pipe_stall);
    end
    rst_n = 1;
    pipe_valid = 0; mdu_busy = 0;
    cyc();
    checks++;
    if (rf_we !== 1'b0 || halted !== 1'b0) begin
      failures++; $display("FAIL async_empty: we=%b halted=%b want 0/0 after release", rf_we, halted);
    end
    $display("test_async_reset: cleared mid-drain without a clock edge");
  endtask

  // Reference: MDU results as a queue, wait count, and a run/drain/halt phase.
  task automatic test_random(input int ncyc);
    logic [4:0]  q_rd[$];
    logic [31:0] q_data[$];
    int          wait_cnt = 0;
    int          phase = 0;      // 0 running, 1 draining, 2 halted
    logic        e_we = 0;
    logic [4:0]  e_addr = 0;
    logic [31:0] e_data = 0;
    logic        e_ready, e_stall, take_mdu, was_empty, popped;
    do_reset();
    for (int n = 0; n < ncyc; n++) begin
      pipe_valid = ($urandom_range(0, 2) != 0);
      pipe_rd    = 5'($urandom_range(0, 31));
      pipe_data  = $urandom;
      mdu_valid  = $urandom_range(0, 1);
      mdu_rd     = 5'($urandom_range(0, 31));
      mdu_data   = $urandom;
      mdu_busy   = ($urandom_range(0, 3) == 0);
      terminate  = ($urandom_range(0, 59) == 0);
      #1;
      e_ready  = (q_rd.size() < DEPTH) && (phase != 2);
      take_mdu = (phase != 2) && (q_rd.size() > 0) && (wait_cnt >= LIMIT || !pipe_valid);
      e_stall  = (phase == 2) || (take_mdu && pipe_valid);
      checks++;
      if (pipe_stall !== e_stall || mdu_ready !== e_ready) begin
        failures++;
        $display("FAIL rand_ctl: cycle %0d stall=%b ready=%b want %b/%b", n, pipe_stall, mdu_ready, e_stall, e_ready);
      end
      was_empty = (q_rd.size() == 0);
      popped = 0;
      if (take_mdu) begin
        e_we = (q_rd[0] != 0); e_addr = q_rd[0]; e_data = q_data[0];
        void'(q_rd.pop_front()); void'(q_data.pop_front());
        popped = 1;
      end else if (phase != 2 && pipe_valid) begin
        e_we = (pipe_rd != 0); e_addr = pipe_rd; e_data = pipe_data;
      end else begin
        e_we = 0;
      end
      if (mdu_valid && e_ready) begin
        q_rd.push_back(mdu_rd); q_data.push_back(mdu_data);
      end
      wait_cnt = (was_empty || popped) ? 0 : ((wait_cnt < LIMIT) ? wait_cnt + 1 : LIMIT);
      if (phase == 0 && terminate) phase = 1;
      else if (phase == 1 && was_empty && !mdu_busy && !mdu_valid) phase = 2;
      cyc();
      checks++;
      if (rf_we !== e_we || rf_waddr !== e_addr || rf_wdata !== e_data || halted !== (phase == 2)) begin
        failures++;
        $display("FAIL rand_rf: cycle %0d we=%b waddr=%0d wdata=%h halted=%b want %b/%0d/%h/%b",
                 n, rf_we, rf_waddr, rf_wdata, halted, e_we, e_addr, e_data, (phase == 2));
      end
      if (phase == 2 && $urandom_range(0, 3) == 0) begin
        rst_n = 0;
        #1;
        rst_n = 1;
        q_rd.delete(); q_data.delete();
        wait_cnt = 0; phase = 0; e_we = 0; e_addr = 0; e_data = 0;
      end
    end
    clear_inputs();
    $display("test_random: %0d cycles compared against reference", ncyc);
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_mdu_idle();
    test_starve();
    test_fifo_full();
    test_drain();
    test_async_reset();
    test_random(2000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
